// File: rtl/seg7_pkg.sv
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and logical segment patterns for the 4-digit
//                multiplexed 7-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Logical (active-high) patterns, segment a in bit 0 through g in bit 6
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

`default_nettype wire

// File: rtl/seg7_digit_rom.sv
// ============================================================================
//  Module      : seg7_digit_rom
//  Description : Combinational BCD nibble to logical 7-segment pattern;
//                non-BCD codes render as a dash.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_digit_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    always_comb begin
        o_pattern = SEG_DASH;
        case (i_nibble)
            4'd0:    o_pattern = SEG_0;
            4'd1:    o_pattern = SEG_1;
            4'd2:    o_pattern = SEG_2;
            4'd3:    o_pattern = SEG_3;
            4'd4:    o_pattern = SEG_4;
            4'd5:    o_pattern = SEG_5;
            4'd6:    o_pattern = SEG_6;
            4'd7:    o_pattern = SEG_7;
            4'd8:    o_pattern = SEG_8;
            4'd9:    o_pattern = SEG_9;
            default: o_pattern = SEG_DASH;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_controller.sv
// ============================================================================
//  Module      : seg7_scan_controller
//  Description : Scans four BCD digits onto a shared 7-segment display with
//                inter-digit blanking, frame-aligned updates and LZ blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_controller
    import seg7_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [15:0]           value,
    input  logic                  load,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  lz_en,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CW          = $clog2(SLOT_CYCLES);
    localparam int C_BLANK_END = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

    localparam logic [CW-1:0]         c_slot_last  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]         c_blank_last = CW'(C_BLANK_END);
    localparam logic                  c_pol        = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] c_an_off     = {NUM_DIGITS{c_pol}};
    localparam logic [6:0]            c_seg_off    = {7{c_pol}};

    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_idx;
    state_t                r_state;
    logic [15:0]           r_stage_val;
    logic [NUM_DIGITS-1:0] r_stage_dp;
    logic                  r_pend;
    logic [15:0]           r_shadow_val;
    logic [NUM_DIGITS-1:0] r_shadow_dp;

    logic                  w_last;
    logic                  w_boundary;
    logic [3:0]            w_nibble;
    logic [15:0]           w_upper;
    logic                  w_suppress;
    logic [6:0]            w_pattern;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_last     = (r_cnt == c_slot_last);
    assign w_boundary = w_last && (r_idx == 2'd3);
    assign w_nibble   = r_shadow_val[{r_idx, 2'b00} +: 4];
    // Shifting the current digit down to bit 0 leaves zero only when it and
    // every more significant digit are zero.
    assign w_upper    = r_shadow_val >> {r_idx, 2'b00};
    assign w_suppress = lz_en && (r_idx != 2'd0) && (w_upper == 16'h0000)
                        && !r_shadow_dp[r_idx];
    assign w_onehot   = NUM_DIGITS'(1) << r_idx;

    seg7_digit_rom u_rom (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_state    <= BLANK;
            an         <= c_an_off;
            seg        <= c_seg_off;
            dp         <= c_pol;
            frame_done <= 1'b0;
        end else if (!enable) begin
            r_state    <= BLANK;
            an         <= c_an_off;
            seg        <= c_seg_off;
            dp         <= c_pol;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_boundary;
            if (w_last) begin
                r_cnt   <= '0;
                r_idx   <= r_idx + 2'd1;
                r_state <= BLANK;
            end else begin
                r_cnt <= r_cnt + CW'(1);
                // ">=" lets a slot resumed after a pause leave BLANK promptly
                if (r_state == BLANK && r_cnt >= c_blank_last) begin
                    r_state <= DRIVE;
                end
            end
            if (r_state == DRIVE) begin
                an  <= w_onehot ^ c_an_off;
                seg <= (w_suppress ? SEG_OFF : w_pattern) ^ c_seg_off;
                dp  <= (!w_suppress && r_shadow_dp[r_idx]) ^ c_pol;
            end else begin
                an  <= c_an_off;
                seg <= c_seg_off;
                dp  <= c_pol;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage_val  <= '0;
            r_stage_dp   <= '0;
            r_pend       <= 1'b0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
        end else begin
            if (enable && w_boundary) begin
                if (r_pend) begin
                    r_shadow_val <= r_stage_val;
                    r_shadow_dp  <= r_stage_dp;
                end
                r_pend <= 1'b0;
            end
            // A load on the boundary cycle is held over to the next frame
            if (load) begin
                r_stage_val <= value;
                r_stage_dp  <= dp_in;
                r_pend      <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_controller.sv
// ============================================================================
//  Module      : tb_seg7_scan_controller
//  Description : Self-checking bench for seg7_scan_controller with a
//                frame-position reference model and a digit table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_controller;

    localparam int SLOT  = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 4 * SLOT;

    typedef struct packed {
        logic [15:0]      v;
        logic [3:0]       d;
        logic             lz;
        logic [3:0][6:0]  s;
        logic [3:0]       ep;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int stepn  = 0;

    // Reference model: a single position within the frame plus value registers
    int          pos;
    bit          prev_en;
    logic [15:0] m_shadow, m_stage;
    logic [3:0]  m_sdp, m_stdp;
    bit          m_pend;
    logic [6:0]  pat_tbl [16];

    logic [6:0]  obs_seg [4];
    logic        obs_dp  [4];
    bit          saw5;
    int          fd_q [$];
    vec_t        vecs [8];

    seg7_scan_controller #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) begin
            obs_seg[i] = 'x;
            obs_dp[i]  = 1'bx;
        end
    endtask

    task automatic step(input string tag);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        int         dig, cyc;
        bit         supp;
        dig   = pos / SLOT;
        cyc   = pos % SLOT;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (!reset && enable) begin
            if (cyc >= BLANK && prev_en) begin
                supp  = lz_en && dig != 0 && (m_shadow >> (4 * dig)) == 16'h0 && !m_sdp[dig];
                e_an  = ~(4'b0001 << dig);
                e_seg = supp ? 7'h7F : ~pat_tbl[m_shadow[4*dig +: 4]];
                e_dp  = supp ? 1'b1 : ~m_sdp[dig];
            end
            e_fd = (pos == FRAME - 1);
        end
        if (reset) begin
            pos = 0; prev_en = 1'b1; m_pend = 1'b0;
            m_shadow = '0; m_stage = '0; m_sdp = '0; m_stdp = '0;
        end else begin
            if (enable && pos == FRAME - 1) begin
                if (m_pend) begin
                    m_shadow = m_stage;
                    m_sdp    = m_stdp;
                end
                m_pend = 1'b0;
            end
            if (load) begin
                m_stage = value; m_stdp = dp_in; m_pend = 1'b1;
            end
            if (enable) pos = (pos + 1) % FRAME;
            prev_en = enable;
        end
        @(posedge clk);
        #1;
        checks++;
        if ({an, seg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
            errors++;
            $display("FAIL %s step %0d: an=%b seg=%b dp=%b fd=%b required an=%b seg=%b dp=%b fd=%b",
                     tag, stepn, an, seg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
        end
        for (int i = 0; i < 4; i++) begin
            if (an == ~(4'b0001 << i)) begin
                obs_seg[i] = seg;
                obs_dp[i]  = dp;
            end
        end
        if (an != 4'hF && seg == 7'h12) saw5 = 1'b1;
        if (frame_done) fd_q.push_back(stepn);
        stepn++;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input string tag);
        value = v; dp_in = d; load = 1'b1;
        step(tag);
        load = 1'b0;
    endtask

    task automatic check_digits(input string name, input logic [3:0][6:0] s, input logic [3:0] ep);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_d%0d", name, i), {obs_seg[i], obs_dp[i]}, {s[i], ep[i]});
        end
    endtask

    initial begin
        pat_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        vecs[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[1] = '{16'h0070, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0070, 4'b0100, 1'b1, {7'h7F, 7'h40, 7'h78, 7'h40}, 4'b1011};
        vecs[3] = '{16'h00B0, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h40}, 4'b1111};
        vecs[4] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[5] = '{16'h5678, 4'b1111, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0000};
        vecs[6] = '{16'hF0A0, 4'b0001, 1'b1, {7'h3F, 7'h40, 7'h3F, 7'h40}, 4'b1110};
        vecs[7] = '{16'h0009, 4'b1000, 1'b1, {7'h40, 7'h7F, 7'h7F, 7'h10}, 4'b0111};

        reset = 1'b1; enable = 1'b1; value = '0; load = 1'b0; dp_in = '0; lz_en = 1'b0;
        pos = 0; prev_en = 1'b1; m_pend = 1'b0;
        m_shadow = '0; m_stage = '0; m_sdp = '0; m_stdp = '0;
        saw5 = 1'b0;
        clear_obs();
        @(negedge clk);

        repeat (3) step("reset");
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1'b1);
        chk("reset_fd", frame_done, 1'b0);

        // First frame after release still shows the cleared shadow
        reset = 1'b0;
        fd_q.delete();
        do_load(16'h1234, 4'b0000, "release");
        repeat (15) step("frame1");
        check_digits("first_frame", {4{7'h40}}, 4'b1111);
        clear_obs();
        repeat (16) step("frame2");
        check_digits("frame2_1234", vecs[0].s, vecs[0].ep);
        repeat (17) step("frame3");
        chk("fd_count", fd_q.size(), 3);
        if (fd_q.size() == 3) begin
            chk("fd_period1", fd_q[1] - fd_q[0], FRAME);
            chk("fd_period2", fd_q[2] - fd_q[1], FRAME);
        end

        for (int r = 0; r < 8; r++) begin
            lz_en = vecs[r].lz;
            do_load(vecs[r].v, vecs[r].d, "table_load");
            repeat (20) step("table_settle");
            clear_obs();
            repeat (17) step("table_obs");
            check_digits($sformatf("table%0d", r), vecs[r].s, vecs[r].ep);
        end

        // Two loads inside one frame: only the later one may ever appear
        lz_en = 1'b0;
        fd_q.delete();
        for (int n = 0; n < 40 && fd_q.size() == 0; n++) step("wait_fd");
        chk("wait_fd_seen", fd_q.size() != 0, 1'b1);
        repeat (3) step("mid");
        do_load(16'h5555, 4'b0000, "load5");
        repeat (3) step("mid");
        do_load(16'h9999, 4'b0000, "load9");
        saw5 = 1'b0;
        repeat (20) step("last_wins");
        clear_obs();
        repeat (17) step("last_wins");
        chk("never_5", saw5, 1'b0);
        check_digits("all9", {4{7'h10}}, 4'b1111);

        // Pause during digit 2 drive, then resume from the held position
        begin
            int n;
            for (n = 0; n < 40 && an !== 4'b1011; n++) step("wait_d2");
            chk("wait_d2_seen", an, 4'b1011);
        end
        enable = 1'b0;
        step("disable");
        chk("disable_an", an, 4'hF);
        chk("disable_seg", seg, 7'h7F);
        repeat (3) step("disabled");
        enable = 1'b1;
        step("reenable");
        chk("reenable_blank", an, 4'hF);
        step("reenable");
        chk("resume_d2", an, 4'b1011);

        // Reset on the boundary cycle: no frame_done, shadow cleared
        begin
            int n;
            for (n = 0; n < 40 && an !== 4'b0111; n++) step("wait_d3");
            chk("wait_d3_seen", an, 4'b0111);
        end
        step("pre_reset");
        fd_q.delete();
        reset = 1'b1;
        step("mid_reset");
        chk("midreset_an", an, 4'hF);
        chk("midreset_fd", frame_done, 1'b0);
        reset = 1'b0;
        begin
            int n;
            for (n = 0; n < 10 && an === 4'hF; n++) step("post_reset");
            chk("post_reset_an", an, 4'b1110);
            chk("post_reset_seg", seg, 7'h40);
        end
        repeat (10) step("post_reset");
        chk("no_fd_after_reset", fd_q.size(), 0);

        for (int n = 0; n < 800; n++) begin
            enable = ($urandom % 10) != 0;
            load   = ($urandom % 6) == 0;
            value  = 16'($urandom);
            dp_in  = 4'($urandom);
            lz_en  = 1'($urandom);
            reset  = ($urandom % 200) == 0;
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Time-multiplexes four BCD digits onto one shared common-anode 7-segment display: one anode selected at a time, the matching BCD nibble decoded onto the shared segment bus.
- Sits between the datapath (which supplies a 16-bit packed BCD value) and the board display pins.
- Adds tear-free value update at frame boundaries, inter-digit blanking against ghosting, and optional leading-zero suppression.

Parameters:
- SLOT_CYCLES, 100000, clock cycles per digit slot; minimum 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be less than SLOT_CYCLES.
- ACTIVE_LOW, 1, 1 means `an`/`seg`/`dp` are driven active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = scanning; 0 = display dark, counters held
- value  in  16  packed BCD; [3:0] is digit 0 (rightmost), [15:12] is digit 3
- load  in  1  1-cycle strobe; requests capture of `value` and `dp_in`
- dp_in  in  4  per-digit decimal point request, bit i belongs to digit i
- lz_en  in  1  1 = suppress leading zeros
- an  out  4  anode selects, bit i drives digit i
- seg  out  7  segments a..g in seg[0]..seg[6]
- dp  out  1  decimal point
- frame_done  out  1  1-cycle pulse at the end of each full 4-digit frame

Behaviour:
- All outputs are registered. "Off" and "on" below are logical levels; physical polarity is set by ACTIVE_LOW.
- Reset (dominates every other input):
  - slot counter = 0, digit index = 0, state = BLANK
  - shadow value = 0, shadow dp = 0, pending flag = 0
  - `an`, `seg`, `dp` all off; `frame_done` = 0
  - Reset asserted mid-frame aborts the frame; no `frame_done` pulse is produced.
- State machine, driven by the slot counter (0..SLOT_CYCLES-1):
  - BLANK: `an` all off, `seg` all off. Move to DRIVE when counter == BLANK_CYCLES-1.
  - DRIVE: `an` has exactly one bit on, the current digit index. `seg` = decode of the shadow nibble. `dp` = shadow dp bit for that digit.
  - When counter == SLOT_CYCLES-1: counter wraps to 0, digit index increments (3 wraps to 0), state returns to BLANK.
- Output timing: outputs reflect the new state on the cycle after the state changes (one-cycle registered latency).
- `frame_done` = 1 for exactly one cycle: the cycle after the last cycle of digit 3's slot.
- Value update:
  - `load` sets the pending flag and captures `value`/`dp_in` into a staging register.
  - Staging is copied to the shadow register only at the frame boundary (digit index 3 → 0 transition); pending then clears.
  - Several loads within one frame: the last one wins.
  - `load` on the same cycle as the boundary is captured into staging and applied at the next boundary.
- Decode, per nibble:
  - 0–9: standard patterns.
  - 10–15 (invalid BCD): segment g only, shown as "-".
- Leading-zero suppression (when `lz_en` = 1):
  - A digit is blanked (seg and dp off, anode still cycled) if its nibble is 0, every higher digit is 0, and it is not digit 0.
  - Digit 0 always displays.
  - A digit with its dp bit set is never suppressed.
- `enable` = 0:
  - Counter and digit index hold; outputs forced off next cycle; `frame_done` = 0.
  - Staging and `load` capture still operate.
  - On re-enable, scanning resumes from the held position, in BLANK.
- Width rule: slot counter width = clog2(SLOT_CYCLES); no overflow path exists.

Decomposition:
- Package `seg7_pkg`:
  - state enum {BLANK, DRIVE}
  - segment pattern constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (logical, active-high)
  - NUM_DIGITS = 4
- One sub-module: `seg7_digit_rom`, a combinational nibble → 7-bit logical pattern. Polarity inversion is applied in the controller's output register stage.

Test Plan (SLOT_CYCLES=4, BLANK_CYCLES=1, ACTIVE_LOW=1):
- Reset held 3 cycles, then released with enable=1, value=16'h1234 loaded → first frame shows 0000. From the second frame, the per-digit DRIVE sequence is:
  - an=1110 with seg = "4"
  - an=1101 with seg = "3"
  - an=1011 with seg = "2"
  - an=0111 with seg = "1"
  - Each digit has 1 blank cycle (an=1111) followed by 3 drive cycles. `frame_done` pulses every 16 cycles.
- value=16'h0070, lz_en=1 → digits 3 and 2 blanked (seg off), digit 1 shows "7", digit 0 shows "0". With dp_in=4'b0100, digit 2 shows "0" with dp on.
- Load 16'h5555 then 16'h9999 in mid-frame → display unchanged until the boundary, then all digits "9"; "5" is never shown.
- value nibble = 4'hB on digit 1 → seg = 7'b0111111 (g only, active-low).
- enable dropped mid-DRIVE of digit 2 → outputs off next cycle, index holds. Re-enable → a BLANK cycle, then digit 2 resumes.
- reset pulsed mid-frame → all outputs off next cycle, digit index 0, shadow cleared, no `frame_done` pulse.
